// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: allocates entries at the tail, accepts CDB results,
// retires the head one entry per cycle and raises a pipeline flush on a mispredicted commit.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ID_valid,
  input  logic [4:0]          ID_rd,
  output logic [ROB_ID_W-1:0] ID_ROB_id,
  output logic                ROB_full,
  input  logic                CDB_valid,
  input  logic [ROB_ID_W-1:0] CDB_ROB_id,
  input  logic [DATA_W-1:0]   CDB_value,
  input  logic                CDB_mispredict,
  input  logic [DATA_W-1:0]   CDB_target_pc,
  input  logic [ROB_ID_W-1:0] Q1_ROB_id,
  input  logic [ROB_ID_W-1:0] Q2_ROB_id,
  output logic                Q1_ready,
  output logic                Q2_ready,
  output logic [DATA_W-1:0]   Q1_value,
  output logic [DATA_W-1:0]   Q2_value,
  output logic                RF_commit_valid,
  output logic [4:0]          RF_commit_rd,
  output logic [ROB_ID_W-1:0] RF_commit_ROB_id,
  output logic [DATA_W-1:0]   RF_commit_value,
  output logic                flush,
  output logic [DATA_W-1:0]   flush_pc
);

  localparam int unsigned CNT_W = ROB_ID_W + 1;

  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] done;
  logic [ROB_SIZE-1:0] mispred;
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [DATA_W-1:0]   value_q  [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];

  logic [ROB_ID_W-1:0] head;
  logic [ROB_ID_W-1:0] tail;
  logic [CNT_W-1:0]    count;

  logic do_commit;
  logic do_flush;
  logic do_alloc;
  logic do_wb;

  // A mispredicted commit wins over any allocation or writeback in the same cycle.
  always_comb begin
    ROB_full  = (count == CNT_W'(ROB_SIZE));
    ID_ROB_id = tail;
    do_commit = rdy && busy[head] && done[head];
    do_flush  = do_commit && mispred[head];
    do_alloc  = rdy && ID_valid && !ROB_full && !do_flush;
    do_wb     = rdy && CDB_valid && busy[CDB_ROB_id] && !do_flush;
  end

  // Operand forwarding: a same-cycle CDB broadcast bypasses the stored entry.
  always_comb begin
    Q1_ready = busy[Q1_ROB_id] && done[Q1_ROB_id];
    Q1_value = value_q[Q1_ROB_id];
    Q2_ready = busy[Q2_ROB_id] && done[Q2_ROB_id];
    Q2_value = value_q[Q2_ROB_id];
    if (CDB_valid && (CDB_ROB_id == Q1_ROB_id)) begin
      Q1_ready = 1'b1;
      Q1_value = CDB_value;
    end
    if (CDB_valid && (CDB_ROB_id == Q2_ROB_id)) begin
      Q2_ready = 1'b1;
      Q2_value = CDB_value;
    end
  end

  // Control state, entry flags and registered commit/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= '0;
      done             <= '0;
      mispred          <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      RF_commit_valid  <= 1'b0;
      RF_commit_rd     <= '0;
      RF_commit_ROB_id <= '0;
      RF_commit_value  <= '0;
      flush            <= 1'b0;
      flush_pc         <= '0;
    end else begin
      RF_commit_valid <= 1'b0;
      flush           <= 1'b0;
      if (do_commit) begin
        RF_commit_valid  <= (rd_q[head] != 5'd0);
        RF_commit_rd     <= rd_q[head];
        RF_commit_ROB_id <= head;
        RF_commit_value  <= value_q[head];
      end
      if (do_flush) begin
        flush    <= 1'b1;
        flush_pc <= target_q[head];
        busy     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (do_wb) begin
          done[CDB_ROB_id]    <= 1'b1;
          mispred[CDB_ROB_id] <= CDB_mispredict;
        end
        if (do_alloc) begin
          busy[tail]    <= 1'b1;
          done[tail]    <= 1'b0;
          mispred[tail] <= 1'b0;
          tail          <= tail + ROB_ID_W'(1);
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + ROB_ID_W'(1);
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload needs no reset: it is only read once the entry's flags qualify it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_wb) begin
        value_q[CDB_ROB_id]  <= CDB_value;
        target_q[CDB_ROB_id] <= CDB_target_pc;
      end
      if (do_alloc) begin
        rd_q[tail] <= ID_rd;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expected commits are queued when results are driven
// and popped when the commit/flush outputs fire.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ID_valid;
  logic [4:0]  ID_rd;
  logic [3:0]  ID_ROB_id;
  logic        ROB_full;
  logic        CDB_valid;
  logic [3:0]  CDB_ROB_id;
  logic [31:0] CDB_value;
  logic        CDB_mispredict;
  logic [31:0] CDB_target_pc;
  logic [3:0]  Q1_ROB_id;
  logic [3:0]  Q2_ROB_id;
  logic        Q1_ready;
  logic        Q2_ready;
  logic [31:0] Q1_value;
  logic [31:0] Q2_value;
  logic        RF_commit_valid;
  logic [4:0]  RF_commit_rd;
  logic [3:0]  RF_commit_ROB_id;
  logic [31:0] RF_commit_value;
  logic        flush;
  logic [31:0] flush_pc;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [3:0]  id;
    logic [31:0] val;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  reorder_buffer #(.ROB_SIZE(16), .ROB_ID_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_valid(ID_valid), .ID_rd(ID_rd), .ID_ROB_id(ID_ROB_id), .ROB_full(ROB_full),
    .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value),
    .CDB_mispredict(CDB_mispredict), .CDB_target_pc(CDB_target_pc),
    .Q1_ROB_id(Q1_ROB_id), .Q2_ROB_id(Q2_ROB_id),
    .Q1_ready(Q1_ready), .Q2_ready(Q2_ready), .Q1_value(Q1_value), .Q2_value(Q2_value),
    .RF_commit_valid(RF_commit_valid), .RF_commit_rd(RF_commit_rd),
    .RF_commit_ROB_id(RF_commit_ROB_id), .RF_commit_value(RF_commit_value),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic v, input logic [4:0] rd, input logic [3:0] id,
                          input logic [31:0] val, input logic fl, input logic [31:0] fpc);
    exp_t e;
    e.v = v; e.rd = rd; e.id = id; e.val = val; e.fl = fl; e.fpc = fpc;
    exp_q.push_back(e);
  endtask

  // Any visible commit or flush must match the oldest queued expectation.
  task automatic check_commit();
    exp_t e;
    if (RF_commit_valid || flush) begin
      if (exp_q.size() == 0) begin
        chk("commit_when_none_expected", 64'(RF_commit_valid | flush), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_valid", 64'(RF_commit_valid), 64'(e.v));
        chk("commit_rd",    64'(RF_commit_rd),    64'(e.rd));
        chk("commit_id",    64'(RF_commit_ROB_id), 64'(e.id));
        chk("commit_value", 64'(RF_commit_value), 64'(e.val));
        chk("commit_flush", 64'(flush),           64'(e.fl));
        if (e.fl) chk("flush_pc", 64'(flush_pc), 64'(e.fpc));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_commit();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    ID_valid = 1'b1;
    ID_rd    = rd;
    step();
    ID_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [31:0] val,
                     input logic mis, input logic [31:0] tpc);
    CDB_valid      = 1'b1;
    CDB_ROB_id     = id;
    CDB_value      = val;
    CDB_mispredict = mis;
    CDB_target_pc  = tpc;
    step();
    CDB_valid      = 1'b0;
    CDB_mispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; ID_valid = 1'b0; ID_rd = '0;
    CDB_valid = 1'b0; CDB_ROB_id = '0; CDB_value = '0; CDB_mispredict = 1'b0;
    CDB_target_pc = '0; Q1_ROB_id = '0; Q2_ROB_id = '0;

    // Reset state
    do_reset();
    chk("rst_full",     64'(ROB_full), 64'd0);
    chk("rst_tail",     64'(ID_ROB_id), 64'd0);
    chk("rst_valid",    64'(RF_commit_valid), 64'd0);
    chk("rst_flush",    64'(flush), 64'd0);
    chk("rst_flush_pc", 64'(flush_pc), 64'd0);
    chk("rst_value",    64'(RF_commit_value), 64'd0);

    // Basic allocate / writeback / commit latency
    alloc(5'd5);
    chk("first_id_next", 64'(ID_ROB_id), 64'd1);
    push_exp(1'b1, 5'd5, 4'd0, 32'h1234, 1'b0, 32'h0);
    cdb(4'd0, 32'h1234, 1'b0, 32'h0);
    chk("no_commit_same_edge", 64'(RF_commit_valid), 64'd0);
    step();
    chk("basic_committed", 64'(exp_q.size()), 64'd0);
    step();
    chk("basic_one_cycle", 64'(RF_commit_valid), 64'd0);

    // Fill to capacity, ignored allocation, wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(5'(i + 1));
    chk("full_set",  64'(ROB_full), 64'd1);
    chk("full_tail", 64'(ID_ROB_id), 64'd0);
    alloc(5'd20);
    chk("full_ignored_tail", 64'(ID_ROB_id), 64'd0);
    chk("full_ignored_full", 64'(ROB_full), 64'd1);
    push_exp(1'b1, 5'd1, 4'd0, 32'h500, 1'b0, 32'h0);
    cdb(4'd0, 32'h500, 1'b0, 32'h0);
    step();
    chk("full_commit_done", 64'(exp_q.size()), 64'd0);
    chk("full_cleared",     64'(ROB_full), 64'd0);
    chk("wrap_next_id",     64'(ID_ROB_id), 64'd0);
    alloc(5'd9);
    chk("wrap_tail_after", 64'(ID_ROB_id), 64'd1);
    chk("wrap_full_again", 64'(ROB_full), 64'd1);

    // Out-of-order writeback, in-order commit
    do_reset();
    alloc(5'd10); alloc(5'd11); alloc(5'd12);
    push_exp(1'b1, 5'd10, 4'd0, 32'hA0, 1'b0, 32'h0);
    push_exp(1'b1, 5'd11, 4'd1, 32'h11, 1'b0, 32'h0);
    push_exp(1'b1, 5'd12, 4'd2, 32'h22, 1'b0, 32'h0);
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    cdb(4'd1, 32'h11, 1'b0, 32'h0);
    chk("ooo_no_early_commit", 64'(exp_q.size()), 64'd3);
    cdb(4'd0, 32'hA0, 1'b0, 32'h0);
    step();
    chk("ooo_first",  64'(exp_q.size()), 64'd2);
    step();
    chk("ooo_second", 64'(exp_q.size()), 64'd1);
    step();
    chk("ooo_third",  64'(exp_q.size()), 64'd0);

    // Mispredict flush drops younger entries and empties the buffer
    do_reset();
    alloc(5'd3); alloc(5'd4);
    cdb(4'd0, 32'h77, 1'b1, 32'h100);
    push_exp(1'b1, 5'd3, 4'd0, 32'h77, 1'b1, 32'h100);
    cdb(4'd1, 32'h88, 1'b0, 32'h0);
    chk("flush_seen",     64'(exp_q.size()), 64'd0);
    chk("flush_tail",     64'(ID_ROB_id), 64'd0);
    chk("flush_not_full", 64'(ROB_full), 64'd0);
    step();
    chk("flush_one_cycle", 64'(flush), 64'd0);
    step(); step();
    chk("flush_no_younger", 64'(RF_commit_valid), 64'd0);
    for (int i = 0; i < 15; i++) alloc(5'd1);
    chk("flush_count_15", 64'(ROB_full), 64'd0);
    alloc(5'd1);
    chk("flush_count_16", 64'(ROB_full), 64'd1);

    // Combinational lookup bypass and rd=0 commit
    do_reset();
    Q1_ROB_id = 4'd3; Q2_ROB_id = 4'd5;
    CDB_valid = 1'b1; CDB_ROB_id = 4'd3; CDB_value = 32'hAB;
    #1;
    chk("q1_bypass_ready", 64'(Q1_ready), 64'd1);
    chk("q1_bypass_value", 64'(Q1_value), 64'hAB);
    chk("q2_not_ready",    64'(Q2_ready), 64'd0);
    CDB_valid = 1'b0;
    #1;
    chk("q1_idle_not_ready", 64'(Q1_ready), 64'd0);
    alloc(5'd0);
    cdb(4'd0, 32'h5, 1'b0, 32'h0);
    Q1_ROB_id = 4'd0;
    #1;
    chk("q1_stored_ready", 64'(Q1_ready), 64'd1);
    chk("q1_stored_value", 64'(Q1_value), 64'h5);
    step();
    chk("rd0_no_rf_write", 64'(RF_commit_valid), 64'd0);
    alloc(5'd7);
    chk("rd0_tail", 64'(ID_ROB_id), 64'd2);
    push_exp(1'b1, 5'd7, 4'd1, 32'h99, 1'b0, 32'h0);
    cdb(4'd1, 32'h99, 1'b0, 32'h0);
    step();
    chk("rd0_head_advanced", 64'(exp_q.size()), 64'd0);

    // rdy low freezes state
    do_reset();
    alloc(5'd6);
    cdb(4'd0, 32'h66, 1'b0, 32'h0);
    rdy = 1'b0; ID_valid = 1'b1; ID_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_commit", 64'(RF_commit_valid), 64'd0);
      chk("stall_tail",      64'(ID_ROB_id), 64'd1);
    end
    ID_valid = 1'b0; rdy = 1'b1;
    push_exp(1'b1, 5'd6, 4'd0, 32'h66, 1'b0, 32'h0);
    step();
    chk("stall_released", 64'(exp_q.size()), 64'd0);

    // Reset during the flush cycle
    alloc(5'd8);
    cdb(4'd1, 32'h88, 1'b1, 32'h200);
    push_exp(1'b1, 5'd8, 4'd1, 32'h88, 1'b1, 32'h200);
    step();
    chk("rstflush_seen", 64'(exp_q.size()), 64'd0);
    do_reset();
    chk("rstflush_valid", 64'(RF_commit_valid), 64'd0);
    chk("rstflush_rd",    64'(RF_commit_rd), 64'd0);
    chk("rstflush_id",    64'(RF_commit_ROB_id), 64'd0);
    chk("rstflush_value", 64'(RF_commit_value), 64'd0);
    chk("rstflush_flush", 64'(flush), 64'd0);
    chk("rstflush_pc",    64'(flush_pc), 64'd0);
    chk("rstflush_tail",  64'(ID_ROB_id), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
